// File: rtl/bram16_arbiter_if.sv
// rtl/bram16_arbiter_if.sv - master/RAM bus bundle for the two-master block RAM arbiter
// Purpose: groups the instruction port, data port and RAM-side signals.
// Ports (slave = arbiter view):
//   i_req/i_adr -> i_dat/i_ack                      instruction fetch port
//   d_req/d_we/d_sel/d_adr/d_wdat -> d_rdat/d_ack   data port
//   mem_di -> mem_a/mem_do/mem_we                   single-port RAM side
interface bram16_arbiter_if;
  logic        i_req;
  logic [15:0] i_adr;
  logic [15:0] i_dat;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_sel;
  logic [15:0] d_adr;
  logic [15:0] d_wdat;
  logic [15:0] d_rdat;
  logic        d_ack;
  logic [15:0] mem_a;
  logic [15:0] mem_do;
  logic        mem_we;
  logic [15:0] mem_di;

  modport slave (
    input  i_req, i_adr, d_req, d_we, d_sel, d_adr, d_wdat, mem_di,
    output i_dat, i_ack, d_rdat, d_ack, mem_a, mem_do, mem_we
  );

  modport master (
    output i_req, i_adr, d_req, d_we, d_sel, d_adr, d_wdat, mem_di,
    input  i_dat, i_ack, d_rdat, d_ack, mem_a, mem_do, mem_we
  );
endinterface

// File: rtl/bram16_arbiter.sv
// rtl/bram16_arbiter.sv - round-robin two-master arbiter for a 16-bit single-port block RAM
// Purpose: arbitrates instruction fetches and data loads/stores onto one RAM,
//   hides the 1-cycle read latency and performs byte-lane stores as read-modify-write.
// Ports:
//   sys_clk  system clock, rising edge
//   sys_rst  asynchronous active-low reset
//   bus      bram16_arbiter_if.slave (instruction port, data port, RAM side)
module bram16_arbiter #(
  parameter bit data_first = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  bram16_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RMW  = 2'd2,
    ACK  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;   // 1 = data port owns the current transaction
  logic        last_q, last_d;     // 1 = data port was served last
  logic [15:0] adr_q, adr_d;
  logic [15:0] wdat_q, wdat_d;
  logic [1:0]  sel_q, sel_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [15:0] i_dat_q, i_dat_d;
  logic [15:0] d_rdat_q, d_rdat_d;

  logic        any_req;
  logic        win_data;
  logic [15:0] mem_a_c;
  logic [15:0] mem_do_c;
  logic        mem_we_c;

  assign any_req = bus.i_req | bus.d_req;
  // On a tie the port that was not served last wins.
  assign win_data = bus.d_req & (~bus.i_req | ~last_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    i_dat_d  = i_dat_q;
    d_rdat_d = d_rdat_q;
    i_ack_d  = 1'b0;
    d_ack_d  = 1'b0;
    mem_a_c  = 16'h0000;
    mem_do_c = 16'h0000;
    mem_we_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = win_data;
          adr_d   = win_data ? bus.d_adr : bus.i_adr;
          wdat_d  = bus.d_wdat;
          sel_d   = bus.d_sel;
          mem_a_c = win_data ? bus.d_adr : bus.i_adr;
          if (win_data && bus.d_we) begin
            case (bus.d_sel)
              2'b11: begin
                mem_we_c = 1'b1;
                mem_do_c = bus.d_wdat;
                d_ack_d  = 1'b1;
                state_d  = ACK;
              end
              2'b00: begin
                // No lanes selected: completes as a store without touching the RAM.
                d_ack_d = 1'b1;
                state_d = ACK;
              end
              default: state_d = RMW;  // this cycle is the read phase
            endcase
          end else begin
            state_d = RD;
          end
        end
      end

      RD: begin
        mem_a_c = adr_q;
        if (grant_q) begin
          d_rdat_d = bus.mem_di;
          d_ack_d  = 1'b1;
        end else begin
          i_dat_d = bus.mem_di;
          i_ack_d = 1'b1;
        end
        state_d = ACK;
      end

      RMW: begin
        mem_a_c  = adr_q;
        mem_we_c = 1'b1;
        mem_do_c = {sel_q[1] ? wdat_q[15:8] : bus.mem_di[15:8],
                    sel_q[0] ? wdat_q[7:0]  : bus.mem_di[7:0]};
        d_ack_d  = 1'b1;
        state_d  = ACK;
      end

      ACK: begin
        // Ack is visible this cycle; a still-held req is only re-examined in IDLE.
        last_d  = grant_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= ~data_first;
      adr_q    <= 16'h0000;
      wdat_q   <= 16'h0000;
      sel_q    <= 2'b00;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      i_dat_q  <= 16'h0000;
      d_rdat_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      sel_q    <= sel_d;
      i_ack_q  <= i_ack_d;
      d_ack_q  <= d_ack_d;
      i_dat_q  <= i_dat_d;
      d_rdat_q <= d_rdat_d;
    end
  end

  assign bus.mem_a  = mem_a_c;
  assign bus.mem_do = mem_do_c;
  // Reset blocks RAM writes immediately, even mid-RMW before the write edge.
  assign bus.mem_we = mem_we_c & sys_rst;
  assign bus.i_ack  = i_ack_q;
  assign bus.d_ack  = d_ack_q;
  assign bus.i_dat  = i_dat_q;
  assign bus.d_rdat = d_rdat_q;

endmodule

// File: doc/bram16_arbiter.md
Name: bram16_arbiter

Overview:
- Two-master front end for the 16-bit single-port block RAM.
- Arbitrates between a read-only instruction-fetch port and a read/write data port using a req/ack handshake.
- Hides the RAM's 1-cycle synchronous read latency from both masters.
- Implements byte-lane stores as read-modify-write, because the RAM has only a full-word write enable.

Parameters:
- data_first, 1: master that wins the first simultaneous contest after reset (1 = data port, 0 = instruction port).

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge.
- sys_rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- i_req  in  1  instruction-fetch request; held high with i_adr stable until i_ack.
- i_adr  in  16  instruction word address.
- i_dat  out  16  fetched word; valid only in the i_ack cycle.
- i_ack  out  1  one-cycle completion pulse, instruction port.
- d_req  in  1  data request; held high with d_we, d_sel, d_adr, d_wdat stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_sel  in  2  byte-lane select for stores: bit1 = [15:8], bit0 = [7:0]; ignored on loads.
- d_adr  in  16  data word address.
- d_wdat  in  16  store data.
- d_rdat  out  16  load data; valid only in the d_ack cycle.
- d_ack  out  1  one-cycle completion pulse, data port.
- mem_a  out  16  RAM address.
- mem_do  out  16  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_di  in  16  RAM read data; reflects mem_a of the previous cycle.

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - state=IDLE; i_ack=d_ack=0; i_dat=d_rdat=0.
  - Grant register, rmw data register and latched address/data are cleared.
  - Last-served register is set so the master named by data_first wins the first contest.
  - mem_we is forced to 0 while sys_rst=0, regardless of inputs.
- Outputs:
  - i_ack, d_ack, i_dat, d_rdat are registered.
  - mem_a, mem_do, mem_we are combinational from state, grant and the winning request.
- States: IDLE, RD, RMW, ACK.
- IDLE:
  - No req: mem_we=0, mem_a=0, mem_do=0.
  - One req: that master is granted.
  - Both req: the master not served last is granted (round-robin). The grant and a copy of the request are latched at the clock edge.
  - In the grant cycle, mem_a = winner address.
  - Load or instruction fetch: mem_we=0; next state RD.
  - Store with d_sel=11: mem_we=1, mem_do=d_wdat; next state ACK. Ack is set at the end of this cycle.
  - Store with d_sel=01 or 10: mem_we=0 (read phase); next state RMW.
  - Store with d_sel=00: no write ever issued; next state ACK; treated as a completed no-op store.
- RD:
  - mem_a = latched address; mem_we=0.
  - At the edge, mem_di is registered into the granted port's data output and that port's ack is set; next state ACK.
- RMW:
  - mem_a = latched address; mem_we=1.
  - mem_do: each lane with d_sel=1 takes latched d_wdat; each lane with d_sel=0 takes mem_di.
  - Ack is set; next state ACK.
- ACK:
  - Granted ack=1 for exactly this cycle; mem_we=0; no new grant.
  - Next state IDLE; last-served updated to the granted master.
  - This state guarantees a held req is not re-granted; masters drop req in the cycle after ack.
- Latency (req seen in IDLE -> ack high): full store 1 cycle; load/fetch 2 cycles; byte store 2 cycles; byte-store no-op (sel=00) 1 cycle.
- Throughput: one transaction per (latency+1) cycles.
- Address: passed through unchanged; word aliasing and wrap are defined by the RAM.
- Losing master: req stays pending, no ack, no side effects; served at the next IDLE.
- Ack outputs: never both high; data outputs hold their value outside ack cycles.
- Request dropped before ack: protocol violation; the transaction still completes and acks.
- Reset mid-transaction: the transaction is aborted with no ack. An RMW write is suppressed if sys_rst is asserted before the write edge.

Test Plan:
- Reset, then d_req load from 0x0010 with RAM[0x0010]=0xBEEF -> d_ack high exactly 2 cycles after the IDLE cycle; d_rdat=0xBEEF; i_ack stays 0.
- Full store d_adr=0x0005, d_wdat=0x1234, d_sel=11 -> mem_we high one cycle with mem_a=0x0005; d_ack next cycle; subsequent load returns 0x1234.
- RAM[0x0007]=0xAABB, store d_sel=01, d_wdat=0x11CC -> RAM[0x0007]=0xAACC. Repeat with d_sel=10, d_wdat=0x22DD -> RAM=0x22CC. d_sel=00 -> RAM unchanged, d_ack still pulses.
- i_req and d_req held continuously from reset, data_first=1 -> grants alternate D,I,D,I over 8 transactions; never two acks in one cycle; each req receives exactly one ack per transaction.
- Instruction fetch i_adr=0x0100 (RAM=0x5A5A) with d_req rising in the RD cycle -> i_dat=0x5A5A with i_ack; data served next, no corruption.
- sys_rst pulsed low asynchronously during RMW read phase -> mem_we never asserts, RAM unchanged, no ack; after release, the first contest follows data_first.
